shift_mix_columns: RTL and testbench
====================================

SHIFT_MIX_COLUMNS -- requirements
Module: shift_mix_columns

Interface
REQ-001 No parameters; SHALL implement the AES forward round stage that follows subBytes (ShiftRows then MixColumns).
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 valid_i  input  1  state_i and last_round_i valid.
REQ-005 ready_o  output  1  stage can accept; transfer occurs on a clock edge where valid_i && ready_o.
REQ-006 state_i  input  [3:0][3:0] x 8  subBytes output, indexed [row][col].
REQ-007 last_round_i  input  1  1 = final AES round, skip MixColumns.
REQ-008 valid_o  output  1  state_o holds a finished result.
REQ-009 ready_i  input  1  downstream accepts; handoff occurs on a clock edge where valid_o && ready_i.
REQ-010 state_o  output  [3:0][3:0] x 8  result, indexed [row][col], driven directly from the internal state register.

Function
REQ-011 FSM states SHALL be IDLE, MIX and DONE; ready_o SHALL be 1 exactly in IDLE, and valid_o SHALL be 1 exactly in DONE.
REQ-012 On acceptance the register SHALL load ShiftRows(state_i): reg[r][c] = state_i[r][(c+r) mod 4].
REQ-013 Acceptance with last_round_i=1 SHALL go IDLE->DONE with no MixColumns: valid_o high 1 cycle after the accept edge.
REQ-014 Acceptance with last_round_i=0 SHALL go IDLE->MIX and clear the 2-bit column counter col to 0.
REQ-015 MIX SHALL apply MixColumns to column col only, one column per cycle, then increment col; leaving col=3 SHALL enter DONE, so valid_o rises 5 cycles after the accept edge.
REQ-016 MixColumns per column (a0..a3 = rows 0..3) SHALL compute: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-017 2x SHALL be {x[6:0],0} XOR (x[7] ? 8'h1B : 0), and 3x SHALL be 2x^x, all 8-bit with no carry out.
REQ-018 In DONE, state_o and valid_o SHALL stay stable until ready_i=1; the handoff edge SHALL return to IDLE.
REQ-019 valid_i SHALL be ignored in MIX and DONE; no same-cycle handoff+accept, leaving one IDLE bubble between results (max throughput 1 block / 6 cycles non-final, 1 / 2 cycles final).
REQ-020 ready_i while not in DONE SHALL have no effect.
REQ-021 state_o outside DONE SHALL be unspecified to consumers, though deterministic (register contents).

Reset
REQ-022 rst_i high SHALL immediately force IDLE, col=0, state register to all zero, valid_o=0 and ready_o=1, independent of clk_i.
REQ-023 Reset mid-MIX or mid-DONE SHALL abort the block with no valid_o pulse, and the first accept after release SHALL behave as from power-up.
REQ-024 No output SHALL glitch to valid_o=1 during or on release of reset.

Verification
REQ-025 FIPS-197 App. B round 1: state_i rows d4e0b81e/27bfb441/11985d52/aef1e530, last_round_i=0 -> after 5 cycles valid_o=1, state_o rows 04e04828/66cbf806/8119d326/e59a7a4c.
REQ-026 Same input with last_round_i=1 -> valid_o=1 after 1 cycle, state_o rows d4e0b81e/bfb44127/5d521198/30aef1e5.
REQ-027 Column vectors placed in column 0 after shift (other columns zero):
- db135345 -> 8e4da1bc
- f20a225c -> 9fdc589d
- c6c6c6c6 -> c6c6c6c6
- d4d4d4d5 -> d5d5d7d6
REQ-028 Backpressure: hold ready_i=0 for 10 cycles in DONE -> valid_o and state_o constant; valid_i asserted meanwhile with new data -> ready_o=0, data not taken; ready_i=1 -> IDLE, next block accepted one cycle later.
REQ-029 Assert rst_i during MIX at col=2 -> valid_o=0, ready_o=1, state_o=0 immediately; a fresh REQ-025 block afterwards produces the REQ-025 result.
REQ-030 Back-to-back stream of 8 random blocks with random ready_i/valid_i and mixed last_round_i -> every result matches the reference model, in order, with no loss or duplication.

Source files
------------

// File: rtl/shift_mix_columns_if.sv
// Handshake bus for the AES ShiftRows/MixColumns stage: upstream valid/ready with
// the subBytes state in, downstream valid/ready with the mixed state out.
interface shift_mix_columns_if;
   logic                    valid_i;
   logic                    ready_o;
   logic [3:0][3:0][7:0]    state_i;
   logic                    last_round_i;
   logic                    valid_o;
   logic                    ready_i;
   logic [3:0][3:0][7:0]    state_o;

   modport slave (
      input  valid_i, state_i, last_round_i, ready_i,
      output ready_o, valid_o, state_o
   );

   modport master (
      output valid_i, state_i, last_round_i, ready_i,
      input  ready_o, valid_o, state_o
   );
endinterface

// File: rtl/shift_mix_columns.sv
// AES forward round stage after subBytes: ShiftRows on accept, then MixColumns one
// column per cycle (skipped in the final round), result held until handed off.
module shift_mix_columns (
   input  logic               clk_i,
   input  logic               rst_i,
   shift_mix_columns_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MIX, DONE} fsm_t;

   fsm_t                    fsm_q, fsm_d;
   logic [1:0]              col_q, col_d;
   logic [3:0][3:0][7:0]    blk_q, blk_d;
   logic [3:0][7:0]         col_in, col_out;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

   function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] a);
      logic [3:0][7:0] b;
      b[0] = xtime(a[0]) ^ mul3(a[1]) ^ a[2]        ^ a[3];
      b[1] = a[0]        ^ xtime(a[1]) ^ mul3(a[2]) ^ a[3];
      b[2] = a[0]        ^ a[1]        ^ xtime(a[2]) ^ mul3(a[3]);
      b[3] = mul3(a[0])  ^ a[1]        ^ a[2]        ^ xtime(a[3]);
      return b;
   endfunction

   // Row r rotates left by r bytes: out[r][c] = in[r][(c+r) mod 4].
   function automatic logic [3:0][3:0][7:0] shift_rows(input logic [3:0][3:0][7:0] s);
      logic [3:0][3:0][7:0] o;
      logic [1:0]           src;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            src     = 2'(r + c);
            o[r][c] = s[r][src];
         end
      end
      return o;
   endfunction

   always_comb begin
      col_in = '0;
      for (int r = 0; r < 4; r++) begin
         col_in[r] = blk_q[r][col_q];
      end
      col_out = mix_col(col_in);
   end

   always_comb begin
      fsm_d = fsm_q;
      col_d = col_q;
      blk_d = blk_q;
      case (fsm_q)
         IDLE: begin
            if (bus.valid_i) begin
               blk_d = shift_rows(bus.state_i);
               col_d = 2'd0;
               fsm_d = bus.last_round_i ? DONE : MIX;
            end
         end
         MIX: begin
            for (int r = 0; r < 4; r++) begin
               blk_d[r][col_q] = col_out[r];
            end
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            if (bus.ready_i) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm_q <= IDLE;
         col_q <= 2'd0;
         blk_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         col_q <= col_d;
         blk_q <= blk_d;
      end
   end

   assign bus.ready_o = (fsm_q == IDLE);
   assign bus.valid_o = (fsm_q == DONE);
   assign bus.state_o = blk_q;

endmodule

// File: tb/tb_shift_mix_columns.sv
// Bench for shift_mix_columns: known-answer table, backpressure, mid-block reset
// and a randomized stream checked against a GF(2^8) matrix reference model.
module tb_shift_mix_columns;

   typedef logic [3:0][3:0][7:0] blk_t;

   typedef struct {
      string nm;
      blk_t  din;
      logic  last;
      blk_t  dexp;
      int    lat;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   shift_mix_columns_if bus ();

   shift_mix_columns dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic blk_t from_rows(input logic [31:0] r0, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] r3);
      blk_t        s;
      logic [31:0] w [4];
      w[0] = r0; w[1] = r1; w[2] = r2; w[3] = r3;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = w[r][31-8*c -: 8];
      return s;
   endfunction

   // Column vector a0..a3 placed so that ShiftRows lands it in column 0.
   function automatic blk_t diag(input logic [31:0] a);
      blk_t s;
      s = '0;
      for (int r = 0; r < 4; r++) s[r][r] = a[31-8*r -: 8];
      return s;
   endfunction

   function automatic blk_t col0(input logic [31:0] b);
      blk_t s;
      s = '0;
      for (int r = 0; r < 4; r++) s[r][0] = b[31-8*r -: 8];
      return s;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
      logic [7:0] p, aa;
      int         bb;
      p = 8'h00; aa = a; bb = m;
      while (bb != 0) begin
         if (bb % 2 == 1) p ^= aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
         bb = bb / 2;
      end
      return p;
   endfunction

   // MixColumns matrix is circulant with first row {2,3,1,1}.
   function automatic int coef(input int r, input int k);
      int d;
      d = (k - r + 4) % 4;
      return (d == 0) ? 2 : (d == 1) ? 3 : 1;
   endfunction

   function automatic blk_t ref_round(input blk_t s, input logic last);
      blk_t sh, o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            sh[r][c] = s[r][(c + r) % 4];
      if (last) return sh;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            o[r][c] = 8'h00;
            for (int k = 0; k < 4; k++) o[r][c] ^= gmul(sh[k][c], coef(r, k));
         end
      return o;
   endfunction

   function automatic blk_t rand_blk();
      blk_t s;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = 8'($urandom);
      return s;
   endfunction

   task automatic handoff();
      @(negedge clk);
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1 bus.ready_i = 1'b0;
   endtask

   task automatic run_vec(input string nm, input blk_t din, input logic last,
                          input blk_t dexp, input int exp_lat);
      int lat;
      @(negedge clk);
      bus.valid_i      = 1'b1;
      bus.state_i      = din;
      bus.last_round_i = last;
      bus.ready_i      = 1'b0;
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      lat = 1;
      while (!bus.valid_o && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
      chk({nm, " data"}, bus.state_o, dexp);
      handoff();
      chk({nm, " back to idle"}, {bus.valid_o, bus.ready_o}, 2'b01);
   endtask

   vec_t vecs [6];
   blk_t fips_in, a_blk, b_blk, held, cur_in, out_s;
   logic cur_last, have, acc, hand;
   int   sent, recv, waited;
   blk_t exp_q [$];

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.last_round_i = 1'b0;
      bus.state_i = '0;

      fips_in = from_rows(32'hd4e0b81e, 32'h27bfb441, 32'h11985d52, 32'haef1e530);
      vecs[0] = '{"fips_round", fips_in, 1'b0,
                  from_rows(32'h04e04828, 32'h66cbf806, 32'h8119d326, 32'he59a7a4c), 5};
      vecs[1] = '{"fips_last", fips_in, 1'b1,
                  from_rows(32'hd4e0b81e, 32'hbfb44127, 32'h5d521198, 32'h30aef1e5), 1};
      vecs[2] = '{"col_db135345", diag(32'hdb135345), 1'b0, col0(32'h8e4da1bc), 5};
      vecs[3] = '{"col_f20a225c", diag(32'hf20a225c), 1'b0, col0(32'h9fdc589d), 5};
      vecs[4] = '{"col_c6c6c6c6", diag(32'hc6c6c6c6), 1'b0, col0(32'hc6c6c6c6), 5};
      vecs[5] = '{"col_d4d4d4d5", diag(32'hd4d4d4d5), 1'b0, col0(32'hd5d5d7d6), 5};

      // Reset takes effect without a clock edge and holds outputs quiet.
      #2 rst = 1'b1;
      #1;
      chk("reset valid/ready", {bus.valid_o, bus.ready_o}, 2'b01);
      chk("reset state", bus.state_o, 128'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset no valid", bus.valid_o, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("release no valid", {bus.valid_o, bus.ready_o}, 2'b01);

      for (int i = 0; i < 6; i++)
         run_vec(vecs[i].nm, vecs[i].din, vecs[i].last, vecs[i].dexp, vecs[i].lat);

      // Backpressure: hold result in DONE while new data is offered.
      a_blk = rand_blk();
      b_blk = rand_blk();
      @(negedge clk);
      bus.valid_i = 1'b1; bus.state_i = a_blk; bus.last_round_i = 1'b0; bus.ready_i = 1'b0;
      @(posedge clk);
      #1 bus.state_i = b_blk; bus.last_round_i = 1'b1;
      waited = 0;
      while (!bus.valid_o && waited < 20) begin
         @(posedge clk);
         #1 waited++;
      end
      chk("bp reached done", bus.valid_o, 1'b1);
      held = bus.state_o;
      chk("bp result", held, ref_round(a_blk, 1'b0));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp hold valid/ready", {bus.valid_o, bus.ready_o}, 2'b10);
         chk("bp hold state", bus.state_o, held);
      end
      @(negedge clk);
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1 bus.ready_i = 1'b0;
      chk("bp handoff idle", {bus.valid_o, bus.ready_o}, 2'b01);
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      chk("bp next accepted", {bus.valid_o, bus.ready_o}, 2'b10);
      chk("bp next data", bus.state_o, ref_round(b_blk, 1'b1));
      handoff();

      // Reset in MIX with col=2 aborts the block.
      @(negedge clk);
      bus.valid_i = 1'b1; bus.state_i = fips_in; bus.last_round_i = 1'b0;
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midmix reset valid/ready", {bus.valid_o, bus.ready_o}, 2'b01);
      chk("midmix reset state", bus.state_o, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("aborted no valid", bus.valid_o, 1'b0);
      end
      run_vec("fips_after_reset", fips_in, 1'b0, vecs[0].dexp, 5);

      // Randomized stream with random handshakes on both sides.
      sent = 0; recv = 0; have = 1'b0; cur_in = '0; cur_last = 1'b0;
      for (int cyc = 0; cyc < 3000 && !(sent == 8 && recv == 8); cyc++) begin
         @(negedge clk);
         if (!have && sent < 8 && $urandom_range(0, 2) != 0) begin
            cur_in   = rand_blk();
            cur_last = 1'($urandom_range(0, 1));
            have     = 1'b1;
         end
         bus.valid_i      = have;
         bus.state_i      = cur_in;
         bus.last_round_i = cur_last;
         bus.ready_i      = ($urandom_range(0, 3) != 0);
         acc   = have && bus.ready_o;
         hand  = bus.valid_o && bus.ready_i;
         out_s = bus.state_o;
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(ref_round(cur_in, cur_last));
            sent++;
            have = 1'b0;
         end
         if (hand) begin
            if (exp_q.size() == 0) chk("stream unexpected result", out_s, 128'h0 - 1);
            else chk("stream result", out_s, exp_q.pop_front());
            recv++;
         end
      end
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      chk("stream counts", {16'(sent), 16'(recv)}, {16'd8, 16'd8});
      repeat (8) @(negedge clk);
      chk("stream no extra", {bus.valid_o, bus.ready_o}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
